// File: rtl/inst_fetch_resp.sv
// ---------------------------------------------------------------------------
// inst_fetch_resp
// Instruction-side responder for the IF stage. A direct-mapped buffer with
// one 32-bit word per line answers fetches with one cycle of registered
// latency. On a miss it asks stall control to hold pc (o_stall_req) and reads
// the word from backing memory over a req/ack handshake.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   i_ce            fetch enable from IF
//   i_pc            fetch address (bits [1:0] ignored)
//   i_flush         redirect: the fetch in flight is void
//   i_inv           single-cycle pulse, invalidates every line
//   o_inst          instruction for the pc presented in the previous cycle
//   o_inst_valid    o_inst carries a real fetch result
//   o_stall_req     hold-pc request (combinational)
//   o_mem_req       backing-memory read request, held until i_mem_ack
//   o_mem_addr      word-aligned read address
//   i_mem_ack       backing memory returns data this cycle
//   i_mem_rdata     read data, valid with i_mem_ack
// ---------------------------------------------------------------------------
module inst_fetch_resp #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ce,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    input  logic        i_inv,
    output logic [31:0] o_inst,
    output logic        o_inst_valid,
    output logic        o_stall_req,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    // MISS: request outstanding for a live fetch.
    // DRAIN: request outstanding but the fetch was flushed; fill only.
    typedef enum logic [1:0] {S_IDLE, S_MISS, S_DRAIN} state_t;

    state_t             r_state;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]        r_data [LINES];
    logic [IDX_W-1:0]   r_midx;
    logic [TAG_W-1:0]   r_mtag;
    logic [31:0]        r_inst;
    logic               r_inst_valid;
    logic               r_mem_req;
    logic [31:0]        r_mem_addr;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic               w_fill_we;

    assign w_idx = i_pc[IDX_W+1:2];
    assign w_tag = i_pc[31:IDX_W+2];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Any returning word is written unless an invalidate lands the same edge.
    assign w_fill_we = (r_state != S_IDLE) && i_mem_ack && !i_inv;

    assign o_stall_req  = (r_state != S_IDLE) || (i_ce && !w_hit && !i_flush);
    assign o_inst       = r_inst;
    assign o_inst_valid = r_inst_valid;
    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_mem_addr;

    // Tag/data storage needs no reset: r_valid gates every use.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_tag[r_midx]  <= r_mtag;
            r_data[r_midx] <= i_mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_midx       <= '0;
            r_mtag       <= '0;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
        end else begin
            if (w_fill_we)
                r_valid[r_midx] <= 1'b1;
            // Later assignment wins: invalidate overrides a same-edge fill.
            if (i_inv)
                r_valid <= '0;

            case (r_state)
                S_IDLE: begin
                    r_inst       <= '0;
                    r_inst_valid <= 1'b0;
                    if (i_ce && !i_flush) begin
                        if (w_hit) begin
                            r_inst       <= r_data[w_idx];
                            r_inst_valid <= 1'b1;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {i_pc[31:2], 2'b00};
                            r_midx     <= w_idx;
                            r_mtag     <= w_tag;
                            r_state    <= S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    r_inst_valid <= 1'b0;
                    if (i_mem_ack) begin
                        // The word is delivered even if an invalidate drops the fill.
                        r_inst       <= i_mem_rdata;
                        r_inst_valid <= i_ce && !i_flush;
                        r_mem_req    <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (i_flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_inst_valid <= 1'b0;
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
